// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and branch handling,
// multi-cycle multiply/divide stall sequencing and a saturating stall counter.
module hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [REG_AW-1:0] i_rsD,
  input  logic [REG_AW-1:0] i_rtD,
  input  logic [REG_AW-1:0] i_rsE,
  input  logic [REG_AW-1:0] i_rtE,
  input  logic [REG_AW-1:0] i_writeRegE,
  input  logic [REG_AW-1:0] i_writeRegM,
  input  logic [REG_AW-1:0] i_writeRegW,
  input  logic              i_regWriteE,
  input  logic              i_regWriteM,
  input  logic              i_regWriteW,
  input  logic              i_memToRegE,
  input  logic              i_mdStartE,
  input  logic              i_branchTakenE,
  input  logic              i_clrStats,
  output logic [1:0]        o_forwardA,
  output logic [1:0]        o_forwardB,
  output logic              o_stallF,
  output logic              o_stallD,
  output logic              o_stallE,
  output logic              o_flushD,
  output logic              o_flushE,
  output logic              o_mdBusy,
  output logic              o_mdDone,
  output logic [CNT_W-1:0]  o_stallCycles
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } state_t;

  localparam logic [3:0] MD_LOAD = 4'(MD_LAT - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [3:0]       r_mdCnt;
  logic [3:0]       w_nextCnt;
  logic [CNT_W-1:0] r_stallCycles;
  logic             w_loadUse;

  // M-stage result is newer than W-stage, so it wins when both match.
  function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] src);
    logic [1:0] sel;
    sel = 2'd0;
    if (i_regWriteM && (i_writeRegM != '0) && (src == i_writeRegM))
      sel = 2'd2;
    else if (i_regWriteW && (i_writeRegW != '0) && (src == i_writeRegW))
      sel = 2'd1;
    return sel;
  endfunction

  always_comb begin
    o_forwardA = 2'd0;
    o_forwardB = 2'd0;
    if (i_rst_n) begin
      o_forwardA = fwdSel(i_rsE);
      o_forwardB = fwdSel(i_rtE);
    end
  end

  assign w_loadUse = i_memToRegE && i_regWriteE && (i_writeRegE != '0) &&
                     ((i_writeRegE == i_rsD) || (i_writeRegE == i_rtD));

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_mdCnt;
    o_stallF    = 1'b0;
    o_stallD    = 1'b0;
    o_stallE    = 1'b0;
    o_flushD    = 1'b0;
    o_flushE    = 1'b0;
    o_mdBusy    = 1'b0;
    o_mdDone    = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_mdStartE) begin
          o_stallF    = 1'b1;
          o_stallD    = 1'b1;
          o_stallE    = 1'b1;
          w_nextState = MD_BUSY;
          w_nextCnt   = MD_LOAD;
        end else if (w_loadUse) begin
          o_stallF = 1'b1;
          o_stallD = 1'b1;
          o_flushE = 1'b1;
        end else if (i_branchTakenE) begin
          o_flushD = 1'b1;
        end
      end
      MD_BUSY: begin
        o_stallF  = 1'b1;
        o_stallD  = 1'b1;
        o_stallE  = 1'b1;
        o_mdBusy  = 1'b1;
        w_nextCnt = r_mdCnt - 4'd1;
        if (r_mdCnt == 4'd1) w_nextState = MD_DONE;
      end
      MD_DONE: begin
        // A new mdStartE here is deliberately ignored; the result slot is still draining.
        o_mdDone    = 1'b1;
        w_nextState = IDLE;
        if (w_loadUse) begin
          o_stallF = 1'b1;
          o_stallD = 1'b1;
          o_flushE = 1'b1;
        end else if (i_branchTakenE) begin
          o_flushD = 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextCnt   = 4'd0;
      end
    endcase

    if (!i_rst_n) begin
      o_stallF = 1'b0;
      o_stallD = 1'b0;
      o_stallE = 1'b0;
      o_flushD = 1'b0;
      o_flushE = 1'b0;
      o_mdBusy = 1'b0;
      o_mdDone = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_mdCnt       <= 4'd0;
      r_stallCycles <= '0;
    end else begin
      r_state <= w_nextState;
      r_mdCnt <= w_nextCnt;
      if (i_clrStats)
        r_stallCycles <= '0;
      else if (o_stallF && (r_stallCycles != '1))
        r_stallCycles <= r_stallCycles + 1'b1;
    end
  end

  assign o_stallCycles = r_stallCycles;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 5: register address width.
REQ-002 Parameter MD_LAT, default 4, legal range 2..16: multiply/divide execute latency in cycles.
REQ-003 Parameter CNT_W, default 16: stall statistics counter width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 rsD, rtD  in  REG_AW  source registers of the instruction in Decode.
REQ-007 rsE, rtE  in  REG_AW  source registers of the instruction in Execute.
REQ-008 writeRegE, writeRegM, writeRegW  in  REG_AW  destination registers in E, M and W.
REQ-009 regWriteE, regWriteM, regWriteW  in  1  destination-write enables in E, M and W.
REQ-010 memToRegE  in  1  instruction in E is a load.
REQ-011 mdStartE  in  1  instruction in E is a multi-cycle multiply/divide.
REQ-012 branchTakenE  in  1  branch resolved taken in E.
REQ-013 clrStats  in  1  synchronous clear of stallCycles.
REQ-014 forwardA, forwardB  out  2  E operand select: 0 = register file, 1 = W result, 2 = M result.
REQ-015 stallF, stallD, stallE  out  1  hold the F, D and E pipeline registers.
REQ-016 flushD, flushE  out  1  bubble the D and E pipeline registers.
REQ-017 mdBusy  out  1  multiply/divide sequencer is occupied.
REQ-018 mdDone  out  1  one-cycle pulse: multiply/divide result is valid.
REQ-019 stallCycles  out  CNT_W  saturating count of cycles with stallF=1.

Function
REQ-020 forwardA shall be 2 when regWriteM=1, writeRegM!=0 and rsE==writeRegM; otherwise 1 when regWriteW=1, writeRegW!=0 and rsE==writeRegW; otherwise 0. forwardB shall follow the same rule using rtE.
REQ-021 forwardA and forwardB shall be combinational and independent of FSM state.
REQ-022 FSM states: IDLE, MD_BUSY, MD_DONE. A REG_AW-independent down-counter mdCnt, 4 bits wide, shall track MD_BUSY.
REQ-023 IDLE with mdStartE=1:
- stallF=stallD=stallE=1 combinationally in the same cycle.
- next state MD_BUSY, mdCnt<=MD_LAT-1.
REQ-024 MD_BUSY:
- stallF=stallD=stallE=1, mdBusy=1, flushD=flushE=0.
- mdCnt decrements each cycle; when mdCnt==1, next state MD_DONE.
- Total stall from the start cycle is therefore exactly MD_LAT cycles.
REQ-025 MD_DONE lasts one cycle: mdDone=1, no md stall, mdStartE ignored; next state IDLE.
REQ-026 Load-use, evaluated in IDLE and MD_DONE only: asserted when memToRegE=1, regWriteE=1, writeRegE!=0, and (writeRegE==rsD or writeRegE==rtD). Effect: stallF=stallD=flushE=1 for that cycle, stallE=0.
REQ-027 Branch, evaluated in IDLE and MD_DONE only: branchTakenE=1 shall assert flushD=1 for that cycle.
REQ-028 Priority within a cycle: mdStartE (IDLE) > load-use > branch. A lower-priority event is fully suppressed while a higher one is active.
REQ-029 stallCycles:
- clrStats=1 -> 0, with priority over increment.
- Otherwise +1 on each cycle with stallF=1.
- Holds at all-ones (no wrap).
REQ-030 In any cycle with none of REQ-023..REQ-027 active, all stall and flush outputs shall be 0.

Reset
REQ-031 rst_n=0 at a rising edge shall set state=IDLE, mdCnt=0 and stallCycles=0.
REQ-032 While rst_n=0, stallF/D/E, flushD/E, mdBusy, mdDone and forwardA/B shall be driven to 0.
REQ-033 Reset during MD_BUSY shall abort the operation; the first cycle after reset is IDLE with no stall.

Verification
REQ-034 regWriteM=1, writeRegM=8, regWriteW=1, writeRegW=8, rsE=8, rtE=0 -> forwardA=2, forwardB=0.
REQ-035 writeRegM=0, regWriteM=1, rsE=0 -> forwardA=0.
REQ-036 MD_LAT=4, mdStartE held high from cycle 0:
- stallF=1 in cycles 0-3 and mdBusy=1 in cycles 1-3.
- mdDone=1 with stallF=0 in cycle 4.
- No retrigger in cycle 4; IDLE in cycle 5.
- stallCycles increases by 4.
REQ-037 memToRegE=1, regWriteE=1, writeRegE=5, rtD=5, branchTakenE=1 -> stallF=stallD=flushE=1, flushD=0.
REQ-038 rst_n=0 for one cycle while mdCnt=2 -> next cycle IDLE, all outputs 0, stallCycles=0.
REQ-039 stallCycles preset to all-ones by stimulus, one further stall cycle -> value unchanged; then clrStats=1 with stallF=1 -> 0.
